// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron trainer (bias option: PERCEPTRON_BIAS_EN).
package perceptron_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    UPDATE,
    EPOCH_END,
    DONE
  } state_t;

  // Wide enough to hold bias plus N_DIM full-scale products without overflow.
  function automatic int acc_width(input int data_w, input int w_w, input int n_dim);
    return data_w + w_w + $clog2(n_dim + 2);
  endfunction

  // Clamps an already-summed value to the signed range of a width-bit register.
  function automatic int sat_add(input int value, input int width);
    int hi;
    int lo;
    hi = (1 << (width - 1)) - 1;
    lo = -hi - 1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/perceptron_mac.sv
// Time-multiplexed signed multiply-accumulate; preload_en restarts the sum from preload.
module perceptron_mac #(
  parameter int DATA_W = 8,
  parameter int W_W    = 8,
  parameter int ACC_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     preload_en,
  input  logic signed [ACC_W-1:0]  preload,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [W_W-1:0]    w,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [DATA_W+W_W-1:0] prod;

  assign prod = x * w;

  // The first term is folded into the restart so a bias written on the previous
  // cycle is already visible to the next sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= (preload_en ? preload : acc)
             + {{(ACC_W-DATA_W-W_W){prod[DATA_W+W_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron training engine: sample store, epoch FSM and weight update around one MAC.
// Optional bias register enabled by defining PERCEPTRON_BIAS_EN.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int N_DIM      = 2,
  parameter int N_SAMPLES  = 4,
  parameter int DATA_W     = 8,
  parameter int W_W        = 8,
  parameter int MAX_EPOCHS = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [N_DIM*DATA_W-1:0]          load_x,
  input  logic                             load_y,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             converged,
  output logic [$clog2(MAX_EPOCHS+1)-1:0]  epoch_count,
  output logic [$clog2(N_SAMPLES+1)-1:0]   err_count,
  output logic [N_DIM*W_W-1:0]             w_out,
  output logic [W_W-1:0]                   bias_out
);

  localparam int ACC_W = acc_width(DATA_W, W_W, N_DIM);
  localparam int SI_W  = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int DI_W  = (N_DIM > 1) ? $clog2(N_DIM) : 1;
  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  localparam int EC_W  = $clog2(MAX_EPOCHS + 1);

  state_t                    state;
  logic signed [DATA_W-1:0]  xs [N_SAMPLES][N_DIM];
  logic                      ys [N_SAMPLES];
  logic signed [W_W-1:0]     w [N_DIM];
  logic signed [W_W-1:0]     w_next [N_DIM];
  logic [CNT_W-1:0]          count;
  logic [SI_W-1:0]           s_idx;
  logic [DI_W-1:0]           d_idx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   preload;
  logic                      pred;
  logic                      err_nz;
  logic                      err_pos;

`ifdef PERCEPTRON_BIAS_EN
  logic signed [W_W-1:0] bias;
  logic signed [W_W-1:0] bias_next;
  assign preload   = {{(ACC_W-W_W){bias[W_W-1]}}, bias};
  assign bias_next = W_W'(sat_add(int'(bias) + (err_pos ? 1 : -1), W_W));
  assign bias_out  = bias;
`else
  assign preload  = '0;
  assign bias_out = '0;
`endif

  perceptron_mac #(
    .DATA_W (DATA_W),
    .W_W    (W_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state == MAC),
    .preload_en (d_idx == '0),
    .preload    (preload),
    .x          (xs[s_idx][d_idx]),
    .w          (w[d_idx]),
    .acc        (acc)
  );

  assign load_ready = (state == IDLE) && (count < CNT_W'(N_SAMPLES));

  assign pred    = ~acc[ACC_W-1] && (acc != '0);
  assign err_pos = ys[s_idx];
  assign err_nz  = ys[s_idx] ^ pred;

  always_comb begin
    for (int unsigned d = 0; d < N_DIM; d++) begin
      w_next[d] = W_W'(sat_add(int'(w[d]) + (err_pos ? int'(xs[s_idx][d]) : -int'(xs[s_idx][d])), W_W));
    end
  end

  for (genvar d = 0; d < N_DIM; d++) begin : g_w_out
    assign w_out[d*W_W +: W_W] = w[d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      s_idx       <= '0;
      d_idx       <= '0;
      epoch_count <= '0;
      err_count   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      for (int unsigned s = 0; s < N_SAMPLES; s++) begin
        ys[s] <= 1'b0;
        for (int unsigned d = 0; d < N_DIM; d++) xs[s][d] <= '0;
      end
      for (int unsigned d = 0; d < N_DIM; d++) w[d] <= '0;
`ifdef PERCEPTRON_BIAS_EN
      bias <= '0;
`endif
    end else if (clear && (state == IDLE || state == DONE)) begin
      state       <= IDLE;
      count       <= '0;
      epoch_count <= '0;
      err_count   <= '0;
      done        <= 1'b0;
      converged   <= 1'b0;
      for (int unsigned d = 0; d < N_DIM; d++) w[d] <= '0;
`ifdef PERCEPTRON_BIAS_EN
      bias <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            for (int unsigned d = 0; d < N_DIM; d++) begin
              xs[count[SI_W-1:0]][d] <= load_x[d*DATA_W +: DATA_W];
            end
            ys[count[SI_W-1:0]] <= load_y;
            count <= count + 1'b1;
          end
          if (start && count == CNT_W'(N_SAMPLES)) begin
            state       <= MAC;
            busy        <= 1'b1;
            done        <= 1'b0;
            converged   <= 1'b0;
            s_idx       <= '0;
            d_idx       <= '0;
            epoch_count <= '0;
            err_count   <= '0;
          end
        end
        MAC: begin
          if (d_idx == DI_W'(N_DIM - 1)) begin
            d_idx <= '0;
            state <= UPDATE;
          end else begin
            d_idx <= d_idx + 1'b1;
          end
        end
        UPDATE: begin
          if (err_nz) begin
            for (int unsigned d = 0; d < N_DIM; d++) w[d] <= w_next[d];
`ifdef PERCEPTRON_BIAS_EN
            bias <= bias_next;
`endif
            err_count <= err_count + 1'b1;
          end
          if (s_idx == SI_W'(N_SAMPLES - 1)) begin
            state <= EPOCH_END;
          end else begin
            s_idx <= s_idx + 1'b1;
            state <= MAC;
          end
        end
        EPOCH_END: begin
          epoch_count <= epoch_count + 1'b1;
          s_idx       <= '0;
          if (err_count == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            converged <= 1'b1;
          end else if (epoch_count + 1'b1 == EC_W'(MAX_EPOCHS)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            converged <= 1'b0;
          end else begin
            err_count <= '0;
            state     <= MAC;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
- Parametrised, self-contained perceptron training engine: stores N_SAMPLES labelled samples of N_DIM signed features and trains N_DIM signed weights with the classic perceptron rule.
- Runs epochs over the stored set until an error-free epoch (converged) or MAX_EPOCHS is reached.
- Uses one time-multiplexed MAC (one multiply per cycle), so area stays small enough for a TinyTapeout tile.
- Sits behind the top-level pin wrapper, which drives load/start and reads weights and status.

Parameters:
- N_DIM, 2, features per sample (≥1)
- N_SAMPLES, 4, stored training samples (≥1)
- DATA_W, 8, signed feature width
- W_W, 8, signed weight/bias width; updates saturate at the two's-complement limits
- MAX_EPOCHS, 15, epoch limit before giving up (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, active-low
- clear  in  1  one-cycle pulse; empties sample store, zeroes weights/bias/status; honoured only in IDLE/DONE
- load_valid  in  1  sample offered
- load_ready  out  1  store can accept a sample
- load_x  in  N_DIM*DATA_W  sample features; dim d at [d*DATA_W +: DATA_W], signed
- load_y  in  1  label (1 = positive class)
- start  in  1  one-cycle pulse; begins training
- busy  out  1  training in progress
- done  out  1  training finished; held until next start or clear
- converged  out  1  valid while done; 1 = last epoch had zero errors
- epoch_count  out  $clog2(MAX_EPOCHS+1)  completed epochs
- err_count  out  $clog2(N_SAMPLES+1)  errors in current/last epoch
- w_out  out  N_DIM*W_W  weights, packed as load_x
- bias_out  out  W_W  bias (0 when bias is compiled out)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. On reset, every output and all internal state goes to 0 (FSM in IDLE, store empty, weights/bias 0), except load_ready, which goes to 1.
- Reset asserted mid-operation aborts training immediately. There is no partial state.
- Load: a sample transfers when load_valid && load_ready. Samples fill slots 0..N_SAMPLES-1 in order.
  - load_ready = (state == IDLE) && (count < N_SAMPLES).
  - When the store is full, load_valid is ignored.
  - load_ready is 0 in DONE; clear is needed before reloading.
- start is accepted only in IDLE with a full store. Otherwise it is ignored, including while busy. The start of a new run from DONE needs clear and reload. Weights are not cleared by start.
- FSM: IDLE → MAC → UPDATE → (MAC next sample | EPOCH_END) → (MAC sample 0 | DONE).
  - MAC: one cycle per feature, accumulating acc += x[d]*w[d] for d = 0..N_DIM-1.
  - acc width: DATA_W+W_W+$clog2(N_DIM+2), signed, no overflow possible.
  - The accumulator is cleared at entry, preloaded with sign-extended bias when bias is enabled.
- UPDATE (1 cycle):
  - pred = (acc > 0), strict.
  - err = y − pred ∈ {−1, 0, +1}.
  - If err ≠ 0: every w[d] ← sat(w[d] + err*x[d]); bias ← sat(bias + err); err_count increments.
  - sat clamps to [−2^(W_W−1), 2^(W_W−1)−1].
- Per-sample latency: N_DIM+1 cycles.
- EPOCH_END (1 cycle): epoch_count increments.
  - If err_count == 0: DONE with converged = 1.
  - Else if epoch_count (after increment) == MAX_EPOCHS: DONE with converged = 0.
  - Else: err_count ← 0 and the next epoch starts at sample 0.
- done, busy: busy = 1 in MAC/UPDATE/EPOCH_END. done and converged assert on the cycle DONE is entered.
- w_out/bias_out track live registers and are stable in IDLE/DONE.
- Simultaneous start and clear: clear wins. Simultaneous load handshake and start: the load completes and start is ignored that cycle unless the store was already full.

Optional Feature:
- Macro PERCEPTRON_BIAS_EN.
- Defined: bias register present, used in MAC preload and updated in UPDATE.
- Undefined: no bias register, acc starts at 0, bias_out tied to 0.

Decomposition:
- Package perceptron_pkg: FSM state enum, and the functions acc_width(DATA_W, W_W, N_DIM) and sat_add(value, width).
- One sub-module, perceptron_mac: signed multiply-accumulate with clear/preload, enable and acc output, instantiated once.
- The sample store and FSM remain in perceptron_trainer.

Test Plan:
- AND gate, bias enabled, defaults. Samples (0,0)/0, (0,1)/0, (1,0)/0, (1,1)/1 → done, converged = 1, epoch_count = 6, w = (2,1), bias = −2.
- XOR (labels 0,1,1,0), bias enabled → done after 15 epochs, converged = 0, epoch_count = 15, err_count ≥ 1.
- Saturation: W_W = 4, a single sample x = (7,7)/1 over repeated runs (clear, reload, start) → weights clamp at 7, never wrap negative.
- Load handshake: offer 6 samples with N_SAMPLES = 4 → exactly 4 accepted, load_ready drops after the 4th; start before the store is full is ignored (busy stays 0).
- Reset mid-training: assert rst_n low during MAC of epoch 2 → all outputs 0 and load_ready = 1 asynchronously, before the next clock edge; after reset, a reload of the AND set reproduces the first scenario's result.
- Bias compiled out, set (1,0)/1, (0,1)/0 → converged = 1, w = (1,0), bias_out = 0, epoch_count = 2.
